// File: rtl/crc_check.sv
// Receive-side CRC checker: recomputes each frame's CRC with the crc_gen engine, compares it
// with the sideband CRC, enforces a frame-length limit and keeps saturating good/bad counters.
module crc_check #(
    parameter int unsigned          DWIDTH    = 512,
    parameter int unsigned          CRC_WIDTH = 16,
    parameter int unsigned          PIPE_LVL  = 0,
    parameter logic [CRC_WIDTH-1:0] CRC_POLY  = 16'hda5f,
    parameter logic [CRC_WIDTH-1:0] INIT      = 16'b0,
    parameter logic [CRC_WIDTH-1:0] XOR_OUT   = 16'b0,
    parameter bit                   REFIN     = 1'b0,
    parameter bit                   REFOUT    = 1'b0,
    parameter int unsigned          MAX_FLITS = 64,
    parameter int unsigned          CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DWIDTH-1:0]    din,
    input  logic                 dlast,
    input  logic                 flitEn,
    input  logic [CRC_WIDTH-1:0] crc_in,
    input  logic                 cnt_clr,
    output logic                 chk_vld,
    output logic                 chk_ok,
    output logic                 chk_oversize,
    output logic [CRC_WIDTH-1:0] crc_calc,
    output logic [CNT_WIDTH-1:0] good_cnt,
    output logic [CNT_WIDTH-1:0] bad_cnt
);

    localparam int unsigned NSEG   = PIPE_LVL + 1;
    localparam int unsigned SEG_W  = (DWIDTH + NSEG - 1) / NSEG;
    localparam int unsigned FCNT_W = $clog2(MAX_FLITS + 2);

    if ((DWIDTH % 8) != 0) begin : g_bad_dwidth
        $fatal(1, "crc_check: DWIDTH must be a multiple of 8");
    end
    if (MAX_FLITS < 1) begin : g_bad_max
        $fatal(1, "crc_check: MAX_FLITS must be at least 1");
    end

    // Bit-serial MSB-first CRC; unrolled this is a pure XOR network, linear in (crc, data).
    function automatic logic [CRC_WIDTH-1:0] crc_shift(input logic [CRC_WIDTH-1:0] crc,
                                                        input logic [DWIDTH-1:0] data);
        logic [CRC_WIDTH-1:0] c;
        c = crc;
        for (int i = int'(DWIDTH) - 1; i >= 0; i--) begin
            if (c[CRC_WIDTH-1] ^ data[i]) c = (c << 1) ^ CRC_POLY;
            else                          c = c << 1;
        end
        return c;
    endfunction

    function automatic logic [CRC_WIDTH-1:0] data_table(input logic [DWIDTH-1:0] data,
                                                         input int unsigned seg);
        logic [DWIDTH-1:0] m;
        for (int unsigned i = 0; i < DWIDTH; i++) m[i] = data[i] & ((i / SEG_W) == seg);
        return crc_shift('0, m);
    endfunction

    function automatic logic [CRC_WIDTH-1:0] crc_table(input logic [CRC_WIDTH-1:0] crc);
        return crc_shift(crc, '0);
    endfunction

    function automatic logic [DWIDTH-1:0] refl_bytes(input logic [DWIDTH-1:0] d);
        logic [DWIDTH-1:0] r;
        for (int unsigned i = 0; i < DWIDTH; i++) r[i] = d[(i / 8) * 8 + 7 - (i % 8)];
        return r;
    endfunction

    function automatic logic [CRC_WIDTH-1:0] refl_crc(input logic [CRC_WIDTH-1:0] c);
        logic [CRC_WIDTH-1:0] r;
        for (int unsigned i = 0; i < CRC_WIDTH; i++) r[i] = c[CRC_WIDTH-1-i];
        return r;
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_OVER} state_t;

    state_t              state, state_nxt;
    logic [FCNT_W-1:0]   fcnt, fcnt_nxt, fnum_c;
    logic                over_tag_c;

    // Frame-length tracking; the oversize tag rides with the last flit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            fcnt  <= '0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        fcnt_nxt   = fcnt;
        over_tag_c = 1'b0;
        fnum_c     = fcnt + FCNT_W'(1);
        if (flitEn) begin
            case (state)
                S_IDLE: begin
                    if (!dlast) begin
                        state_nxt = S_ACTIVE;
                        fcnt_nxt  = FCNT_W'(1);
                    end
                end
                S_ACTIVE: begin
                    if (dlast) begin
                        over_tag_c = (fnum_c > FCNT_W'(MAX_FLITS));
                        state_nxt  = S_IDLE;
                        fcnt_nxt   = '0;
                    end else if (fnum_c > FCNT_W'(MAX_FLITS)) begin
                        state_nxt = S_OVER;
                    end else begin
                        fcnt_nxt = fnum_c;
                    end
                end
                S_OVER: begin
                    if (dlast) begin
                        over_tag_c = 1'b1;
                        state_nxt  = S_IDLE;
                        fcnt_nxt   = '0;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    logic [DWIDTH-1:0]    in_pd, st_pd;
    logic [CRC_WIDTH-1:0] st_acc, st_c;
    logic                 st_v, st_l, st_o;

    assign in_pd = REFIN ? refl_bytes(din) : din;

    // Data XOR tree split into NSEG segments, one absorbed per stage; sideband delayed alongside.
    if (PIPE_LVL == 0) begin : g_nopipe
        assign st_pd  = in_pd;
        assign st_acc = '0;
        assign st_v   = flitEn;
        assign st_l   = dlast;
        assign st_o   = over_tag_c;
        assign st_c   = crc_in;
    end else begin : g_pipe
        logic [DWIDTH-1:0]    q_pd  [PIPE_LVL];
        logic [CRC_WIDTH-1:0] q_acc [PIPE_LVL];
        logic [CRC_WIDTH-1:0] q_c   [PIPE_LVL];
        logic                 q_v   [PIPE_LVL];
        logic                 q_l   [PIPE_LVL];
        logic                 q_o   [PIPE_LVL];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int unsigned s = 0; s < PIPE_LVL; s++) begin
                    q_v[s] <= 1'b0;
                    q_l[s] <= 1'b0;
                end
            end else begin
                q_v[0] <= flitEn;
                q_l[0] <= dlast;
                for (int unsigned s = 1; s < PIPE_LVL; s++) begin
                    q_v[s] <= q_v[s-1];
                    q_l[s] <= q_l[s-1];
                end
            end
            q_pd[0]  <= in_pd;
            q_acc[0] <= data_table(in_pd, 0);
            q_o[0]   <= over_tag_c;
            q_c[0]   <= crc_in;
            for (int unsigned s = 1; s < PIPE_LVL; s++) begin
                q_pd[s]  <= q_pd[s-1];
                q_acc[s] <= q_acc[s-1] ^ data_table(q_pd[s-1], s);
                q_o[s]   <= q_o[s-1];
                q_c[s]   <= q_c[s-1];
            end
        end

        assign st_pd  = q_pd[PIPE_LVL-1];
        assign st_acc = q_acc[PIPE_LVL-1];
        assign st_v   = q_v[PIPE_LVL-1];
        assign st_l   = q_l[PIPE_LVL-1];
        assign st_o   = q_o[PIPE_LVL-1];
        assign st_c   = q_c[PIPE_LVL-1];
    end

    logic [CRC_WIDTH-1:0] crc_prev, crc_raw, crc_in_d, crc_next_c, crc_fin_c;
    logic                 last_d, over_d;

    assign crc_next_c = st_acc ^ data_table(st_pd, PIPE_LVL) ^ crc_table(crc_prev);
    assign crc_fin_c  = (REFOUT ? refl_crc(crc_raw) : crc_raw) ^ XOR_OUT;

    // CRC feedback register plus the crc_gen-equivalent output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_prev <= INIT;
            crc_raw  <= '0;
            crc_in_d <= '0;
            last_d   <= 1'b0;
            over_d   <= 1'b0;
        end else begin
            if (st_v) crc_prev <= st_l ? INIT : crc_next_c;
            crc_raw  <= crc_next_c;
            crc_in_d <= st_c;
            last_d   <= st_v & st_l;
            over_d   <= st_o;
        end
    end

    // Compare stage and statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_vld      <= 1'b0;
            chk_ok       <= 1'b0;
            chk_oversize <= 1'b0;
            crc_calc     <= '0;
        end else begin
            chk_vld <= last_d;
            if (last_d) begin
                crc_calc     <= crc_fin_c;
                chk_ok       <= (crc_fin_c == crc_in_d) & ~over_d;
                chk_oversize <= over_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            good_cnt <= '0;
            bad_cnt  <= '0;
        end else if (chk_vld) begin
            if (chk_ok) begin
                if (~&good_cnt) good_cnt <= good_cnt + CNT_WIDTH'(1);
            end else begin
                if (~&bad_cnt) bad_cnt <= bad_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule
